// File: rtl/serdes_word_aligner.sv
// serdes_word_aligner: finds the bit offset at which SYNC_PATTERN appears in a
// deserialized 8-bit stream, verifies it over LOCK_COUNT consecutive words,
// then emits realigned words while locked.
//
// Ports:
//   CLK, RST          sole clock (rising edge), synchronous active-high reset
//   din, din_valid    deserializer word (din[0] newest bit) and its qualifier
//   realign           single-cycle request to drop lock and search again
//   train             link is sending SYNC_PATTERN continuously
//   dout, dout_valid  aligned word, one cycle after the input word
//   locked            alignment established
//   offset            selected bit offset k into {prev, din}
//   lock_lost         one-cycle pulse when lock is dropped by miss detection
//
// Optional feature: define SERDES_ALIGNER_LOSS_DETECT_EN to drop lock after
// MISS_LIMIT consecutive mismatches while train is high.

module serdes_word_aligner #(
  parameter logic [7:0]  SYNC_PATTERN = 8'h5C,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned MISS_LIMIT   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       realign,
  input  logic       train,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       locked,
  output logic [2:0] offset,
  output logic       lock_lost
);

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned OW  = 3;
  localparam int unsigned NK  = 8;
  localparam int unsigned CAT = 2 * W - 1;  // top bit of {prev,din} is never selected

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  prev_q, prev_d;
  logic          primed_q, primed_d;
  logic [CW-1:0] match_q, match_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          locked_q, locked_d;
  logic [OW-1:0] offset_q, offset_d;
  logic          lock_lost_q, lock_lost_d;

  logic [CAT-1:0] cat;
  logic [W-1:0]   cand [NK];
  logic [W-1:0]   cand_sel;
  logic           hit;
  logic [OW-1:0]  hit_k;
  logic [CW-1:0]  match_inc;

`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
  logic [CW-1:0] miss_q, miss_d;
  logic [CW-1:0] miss_inc;
  logic          unused_c;
  assign unused_c = prev_q[W-1];
`else
  logic unused_c;
  assign unused_c = ^{prev_q[W-1], train, CW'(MISS_LIMIT)};
`endif

  // Candidate windows and lowest-offset pattern search
  always_comb begin
    cat   = {prev_q[W-2:0], din};
    hit   = 1'b0;
    hit_k = '0;
    for (int k = 0; k < NK; k++) begin
      cand[k] = cat[k +: W];
    end
    for (int k = NK - 1; k >= 0; k--) begin
      if (cand[k] == SYNC_PATTERN) begin
        hit   = 1'b1;
        hit_k = OW'(k);
      end
    end
    cand_sel = cand[offset_q];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    prev_d       = din_valid ? din : prev_q;
    primed_d     = primed_q | din_valid;
    match_d      = match_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    offset_d     = offset_q;
    lock_lost_d  = 1'b0;
    match_inc    = (match_q == '1) ? match_q : match_q + CW'(1);
`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
    miss_d       = miss_q;
    miss_inc     = (miss_q == '1) ? miss_q : miss_q + CW'(1);
`endif

    if (realign) begin
      state_d = SEARCH;
      match_d = '0;
`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
      miss_d  = '0;
`endif
    end else if (din_valid) begin
      unique case (state_q)
        SEARCH: begin
          // prev holds no real data until the first word after reset
          if (primed_q && hit) begin
            offset_d = hit_k;
            match_d  = CW'(1);
            state_d  = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (cand_sel == SYNC_PATTERN) begin
            match_d = match_inc;
            if (match_inc == CW'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            // the failing word is dropped, not re-searched
            state_d = SEARCH;
            match_d = '0;
          end
        end
        LOCKED: begin
          dout_d       = cand_sel;
          dout_valid_d = 1'b1;
`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
          if (train) begin
            if (cand_sel != SYNC_PATTERN) begin
              miss_d = miss_inc;
              if (miss_inc >= CW'(MISS_LIMIT)) begin
                state_d     = SEARCH;
                match_d     = '0;
                miss_d      = '0;
                lock_lost_d = 1'b1;
              end
            end else begin
              miss_d = '0;
            end
          end
`endif
        end
        default: state_d = SEARCH;
      endcase
    end

`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
    // misses only accumulate across an unbroken training interval
    if (!train) miss_d = '0;
`endif

    locked_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= SEARCH;
      prev_q       <= '0;
      primed_q     <= 1'b0;
      match_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      offset_q     <= '0;
      lock_lost_q  <= 1'b0;
`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
      miss_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      primed_q     <= primed_d;
      match_q      <= match_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      locked_q     <= locked_d;
      offset_q     <= offset_d;
      lock_lost_q  <= lock_lost_d;
`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
      miss_q       <= miss_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign offset     = offset_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_serdes_word_aligner.sv
// tb_serdes_word_aligner: directed vectors for serdes_word_aligner with
// hand-computed expectations (default parameters: 8'h5C, LOCK_COUNT=4,
// MISS_LIMIT=3).

module tb_serdes_word_aligner;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] din;
  logic       din_valid;
  logic       realign;
  logic       train;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [2:0] offset;
  logic       lock_lost;

  int n_vec = 0;
  int n_err = 0;

  serdes_word_aligner dut (
    .CLK        (CLK),
    .RST        (RST),
    .din        (din),
    .din_valid  (din_valid),
    .realign    (realign),
    .train      (train),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .offset     (offset),
    .lock_lost  (lock_lost)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, return 1 time unit after the rising edge
  task automatic step(input logic [7:0] d, input logic v, input logic ra, input logic tr);
    @(negedge CLK);
    RST = 1'b0; din = d; din_valid = v; realign = ra; train = tr;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] d, input logic v);
    @(negedge CLK);
    RST = 1'b1; din = d; din_valid = v; realign = 1'b0; train = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_dout",       32'(dout),       32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    check("rst_locked",     32'(locked),     32'h0);
    check("rst_offset",     32'(offset),     32'h0);
    check("rst_lock_lost",  32'(lock_lost),  32'h0);
  endtask

  initial begin
    RST = 1'b1; din = '0; din_valid = 1'b0; realign = 1'b0; train = 1'b0;
    do_reset(8'h00, 1'b0);

    // Unshifted 5C stream: word 1 ignored, words 2..5 match, lock after word 5
    for (int i = 1; i <= 4; i++) begin
      step(8'h5C, 1'b1, 1'b0, 1'b0);
      check("a_locked_early", 32'(locked), 32'h0);
    end
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    check("a_locked",      32'(locked),     32'h1);
    check("a_offset",      32'(offset),     32'h0);
    check("a_dv_lockword", 32'(dout_valid), 32'h0);
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    check("a_dout",        32'(dout),       32'h5C);
    check("a_dv",          32'(dout_valid), 32'h1);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    check("a_idle_dv",     32'(dout_valid), 32'h0);
    check("a_idle_dout",   32'(dout),       32'h5C);
    check("a_idle_locked", 32'(locked),     32'h1);

    // Reset while locked
    do_reset(8'h5C, 1'b1);

    // Stream delayed 3 bits: every word is rotl(5C,3) = E2, offset 3
    for (int i = 1; i <= 4; i++) begin
      step(8'hE2, 1'b1, 1'b0, 1'b0);
      check("b_locked_early", 32'(locked), 32'h0);
    end
    step(8'hE2, 1'b1, 1'b0, 1'b0);
    check("b_locked", 32'(locked), 32'h1);
    check("b_offset", 32'(offset), 32'h3);
    for (int i = 0; i < 3; i++) begin
      step(8'hE2, 1'b1, 1'b0, 1'b0);
      check("b_dout", 32'(dout),       32'h5C);
      check("b_dv",   32'(dout_valid), 32'h1);
    end

    // Third VERIFY word corrupted, then four clean matches relock
    do_reset(8'h00, 1'b0);
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    check("c_locked_bad", 32'(locked), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(8'h5C, 1'b1, 1'b0, 1'b0);
      check("c_locked_rematch", 32'(locked), 32'h0);
    end
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    check("c_relocked", 32'(locked), 32'h1);

    // Realign coincident with a valid word while locked
    step(8'h5C, 1'b1, 1'b1, 1'b0);
    check("d_dv_suppressed", 32'(dout_valid), 32'h0);
    check("d_locked_drop",   32'(locked),     32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(8'h5C, 1'b1, 1'b0, 1'b0);
      check("d_locked_early", 32'(locked), 32'h0);
    end
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    check("d_relocked", 32'(locked), 32'h1);
    check("d_offset",   32'(offset), 32'h0);
    step(8'h5C, 1'b1, 1'b0, 1'b0);
    check("d_dv", 32'(dout_valid), 32'h1);

    // Bad words during training
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    check("e_dout1",   32'(dout),      32'hFF);
    check("e_locked1", 32'(locked),    32'h1);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    check("e_locked2", 32'(locked),    32'h1);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
`ifdef SERDES_ALIGNER_LOSS_DETECT_EN
    check("e_lock_lost", 32'(lock_lost), 32'h1);
    check("e_locked3",   32'(locked),    32'h0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    check("e_lost_pulse", 32'(lock_lost), 32'h0);
    check("e_offset_held", 32'(offset), 32'h0);
    for (int i = 1; i <= 4; i++) step(8'h5C, 1'b1, 1'b0, 1'b1);
    check("e_relocked", 32'(locked), 32'h1);
`else
    check("e_lock_lost", 32'(lock_lost), 32'h0);
    check("e_locked3",   32'(locked),    32'h1);
    step(8'h5C, 1'b1, 1'b0, 1'b1);
`endif
    // Two misses then a match keep lock; the match clears the miss count
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    step(8'h5C, 1'b1, 1'b0, 1'b1);
    check("f_locked",    32'(locked),    32'h1);
    check("f_lock_lost", 32'(lock_lost), 32'h0);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    step(8'hFF, 1'b1, 1'b0, 1'b1);
    check("f_locked_after", 32'(locked),    32'h1);
    check("f_lost_after",   32'(lock_lost), 32'h0);

    // Reset mid-lock: no lock_lost pulse
    do_reset(8'h5C, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    check("g_locked_post", 32'(locked), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
